// File: rtl/num_seg_pkg.sv
// Shared constants for the 13-segment digit encoder: bit map, digit patterns, FSM states.
package num_seg_pkg;

  localparam int SEG_W = 13;

  localparam int BAR_TOP = 12;
  localparam int BAR_UR  = 11;
  localparam int BAR_LR  = 10;
  localparam int BAR_BOT = 9;
  localparam int BAR_LL  = 8;
  localparam int BAR_UL  = 7;
  localparam int BAR_MID = 6;

  localparam int CRN_TL = 5;
  localparam int CRN_TR = 4;
  localparam int CRN_MR = 3;
  localparam int CRN_BR = 2;
  localparam int CRN_BL = 1;
  localparam int CRN_ML = 0;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  // A corner joint lights whenever any bar meeting it is lit.
  function automatic logic [SEG_W-1:0] add_corners(input logic [SEG_W-1:0] bars);
    logic [SEG_W-1:0] m;
    m = bars;
    m[CRN_TL] = bars[BAR_TOP] | bars[BAR_UL];
    m[CRN_TR] = bars[BAR_TOP] | bars[BAR_UR];
    m[CRN_MR] = bars[BAR_UR]  | bars[BAR_LR] | bars[BAR_MID];
    m[CRN_BR] = bars[BAR_LR]  | bars[BAR_BOT];
    m[CRN_BL] = bars[BAR_BOT] | bars[BAR_LL];
    m[CRN_ML] = bars[BAR_UL]  | bars[BAR_LL] | bars[BAR_MID];
    return m;
  endfunction

  localparam logic [SEG_W-1:0] BLANK = '0;
  localparam logic [SEG_W-1:0] DASH  = add_corners(13'h0040);

  localparam logic [9:0][SEG_W-1:0] DIGIT_TABLE = {
    add_corners(13'h1EC0),  // 9
    add_corners(13'h1FC0),  // 8
    add_corners(13'h1C00),  // 7
    add_corners(13'h17C0),  // 6
    add_corners(13'h16C0),  // 5
    add_corners(13'h0CC0),  // 4
    add_corners(13'h1E40),  // 3
    add_corners(13'h1B40),  // 2
    add_corners(13'h0C00),  // 1
    add_corners(13'h1F80)   // 0
  };

endpackage

// File: rtl/num_seg_encoder_seg13_lut.sv
// Combinational BCD digit to 13-bit segment mask; non-decimal codes render blank.
module seg13_lut
  import num_seg_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] mask
);

  always_comb begin
    mask = BLANK;
    if (digit <= 4'd9) mask = DIGIT_TABLE[digit];
  end

endmodule

// File: rtl/num_seg_encoder.sv
// Binary to BCD (double-dabble) to per-digit segment masks, committed on frame_start.
// Define NUMSEG_LZB_EN to blank leading zero digits.
module num_seg_encoder
  import num_seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VAL_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VAL_W-1:0]        in_value,
  input  logic                    frame_start,
  output logic [DIGITS*SEG_W-1:0] seg_out,
  output logic                    busy
);

  localparam int CNT_W = $clog2(VAL_W);
  localparam int BCD_W = DIGITS * 4;
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VAL);

  state_t                    state_q, state_d;
  logic [VAL_W-1:0]          value_q, value_d;
  logic [BCD_W-1:0]          bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic [DIGITS*SEG_W-1:0]   pending_q, pending_d;
  logic                      pending_valid_q, pending_valid_d;
  logic [DIGITS*SEG_W-1:0]   seg_q, seg_d;
  logic [DIGITS-1:0][3:0]    digit_code;
  logic [DIGITS-1:0][SEG_W-1:0] lut_mask;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == SHIFT) || (state_q == ENCODE);
  assign seg_out  = seg_q;

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
  end

`ifdef NUMSEG_LZB_EN
  always_comb begin
    logic lead_zero;
    lead_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lead_zero = lead_zero && (bcd_q[4*k +: 4] == 4'd0) && (k != 0);
      digit_code[k] = lead_zero ? 4'hF : bcd_q[4*k +: 4];
    end
  end
`else
  assign digit_code = bcd_q;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_lut
    seg13_lut u_lut (
      .digit (digit_code[g]),
      .mask  (lut_mask[g])
    );
  end

  always_comb begin
    state_d         = state_q;
    value_d         = value_q;
    bcd_d           = bcd_q;
    cnt_d           = cnt_q;
    ovf_d           = ovf_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    seg_d           = seg_q;

    // Commit uses the old pending content even when ENCODE writes a new one this cycle.
    if (frame_start && pending_valid_q) begin
      seg_d           = pending_q;
      pending_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          value_d = in_value;
          ovf_d   = (in_value > MAX_V);
          bcd_d   = '0;
          cnt_d   = CNT_W'(VAL_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A carry out of the top nibble only happens for inputs already flagged out of range.
        ovf_d   = ovf_q | bcd_adj[BCD_W-1];
        bcd_d   = {bcd_adj[BCD_W-2:0], value_q[VAL_W-1]};
        value_d = {value_q[VAL_W-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ENCODE;
      end
      ENCODE: begin
        pending_d       = ovf_q ? {DIGITS{DASH}} : lut_mask;
        pending_valid_d = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      value_q         <= '0;
      bcd_q           <= '0;
      cnt_q           <= '0;
      ovf_q           <= 1'b0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      seg_q           <= '0;
    end else begin
      state_q         <= state_d;
      value_q         <= value_d;
      bcd_q           <= bcd_d;
      cnt_q           <= cnt_d;
      ovf_q           <= ovf_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      seg_q           <= seg_d;
    end
  end

endmodule

// File: tb/tb_num_seg_encoder.sv
// Directed self-checking bench for num_seg_encoder with hand-computed segment masks.
// Honours NUMSEG_LZB_EN for the leading-zero expectations.
module tb_num_seg_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_value;
  logic        frame_start;
  logic [51:0] seg_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int busy_cycles;
  int ready_low;

  localparam logic [12:0] P0 = 13'h1FBF, P1 = 13'h0C1C, P2 = 13'h1B7F, P3 = 13'h1E7F,
                          P4 = 13'h0CFD, P6 = 13'h17FF, P7 = 13'h1C3C,
                          P8 = 13'h1FFF, P9 = 13'h1EFF, PD = 13'h0049, PB = 13'h0000;

  num_seg_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .frame_start (frame_start),
    .seg_out     (seg_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Sends one value and follows the conversion until busy drops (bounded).
  task automatic applyStimulus(input logic [13:0] v, input bit glitch, input bit fs_at_encode);
    in_value = v;
    in_valid = 1'b1;
    tick();
    in_valid    = 1'b0;
    busy_cycles = 0;
    ready_low   = 0;
    while (busy && busy_cycles < 100) begin
      if (!in_ready) ready_low++;
      if (glitch && busy_cycles == 3) begin
        in_valid = 1'b1;
        in_value = 14'd2222;
      end
      if (fs_at_encode && busy_cycles == 14) frame_start = 1'b1;
      tick();
      in_valid    = 1'b0;
      in_value    = v;
      frame_start = 1'b0;
      busy_cycles++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_value    = '0;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_seg", seg_out, 64'd0);
    checkOutput("reset_ready", in_ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    pulseFrame();
    checkOutput("idle_frame_seg", seg_out, 64'd0);

    applyStimulus(14'd1234, 1'b0, 1'b0);
    checkOutput("busy_len_1234", busy_cycles, 15);
    checkOutput("ready_low_1234", ready_low, 15);
    repeat (4) tick();
    checkOutput("pre_commit_1234", seg_out, 64'd0);
    pulseFrame();
    checkOutput("commit_1234", seg_out, {P1, P2, P3, P4});

    applyStimulus(14'd10000, 1'b0, 1'b0);
    pulseFrame();
    checkOutput("overflow_10000", seg_out, {4{PD}});

    applyStimulus(14'd9999, 1'b0, 1'b0);
    pulseFrame();
    checkOutput("max_9999", seg_out, {4{P9}});

    applyStimulus(14'd7, 1'b0, 1'b0);
    pulseFrame();
`ifdef NUMSEG_LZB_EN
    checkOutput("value_7", seg_out, {PB, PB, PB, P7});
`else
    checkOutput("value_7", seg_out, {P0, P0, P0, P7});
`endif

    applyStimulus(14'd0, 1'b0, 1'b0);
    pulseFrame();
`ifdef NUMSEG_LZB_EN
    checkOutput("value_0", seg_out, {PB, PB, PB, P0});
`else
    checkOutput("value_0", seg_out, {4{P0}});
`endif

    applyStimulus(14'd5, 1'b0, 1'b0);
    applyStimulus(14'd60, 1'b0, 1'b0);
    pulseFrame();
`ifdef NUMSEG_LZB_EN
    checkOutput("latest_wins_60", seg_out, {PB, PB, P6, P0});
`else
    checkOutput("latest_wins_60", seg_out, {P0, P0, P6, P0});
`endif
    pulseFrame();
    checkOutput("no_pending_hold", seg_out[25:0], {P6, P0});

    applyStimulus(14'd8888, 1'b0, 1'b0);
    pulseFrame();
    checkOutput("commit_8888", seg_out, {4{P8}});
    applyStimulus(14'd1111, 1'b1, 1'b1);
    checkOutput("busy_len_glitch", busy_cycles, 15);
    checkOutput("encode_frame_hold", seg_out, {4{P8}});
    pulseFrame();
    checkOutput("commit_1111", seg_out, {4{P1}});

    in_value = 14'd4321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    checkOutput("midconv_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_seg", seg_out, 64'd0);
    checkOutput("midreset_ready", in_ready, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    checkOutput("postreset_busy", busy, 1'b0);
    pulseFrame();
    checkOutput("postreset_frame_seg", seg_out, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
